// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: shared default geometry for the FIFO and its storage array.
package async_fifo_pkg;
    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_FIFO_SIZE = 16;
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: FIFO_SIZE x WIDTH register array with one synchronous write port
// and one combinational read-address port; no reset on the contents.
module fifo_mem
    import async_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_FIFO_SIZE,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/async_fifo.sv
// async_fifo: single-clock FIFO with wrap-bit pointers, full/empty flags,
// registered read data and one-cycle overflow/underflow pulses.
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int FIFO_SIZE = DEFAULT_FIFO_SIZE
) (
    input  logic             wr_clk,
    input  logic             res,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);
    localparam int PTR_WIDTH = $clog2(FIFO_SIZE);
    localparam logic [PTR_WIDTH:0] PTR_ONE = {{PTR_WIDTH{1'b0}}, 1'b1};

    logic [PTR_WIDTH:0] wptr, rptr;
    logic [WIDTH-1:0]   mem_rdata;
    logic               wr_ok, rd_ok;

    // MSB is the wrap toggle: equal addresses mean empty or full depending on it
    assign empty = wptr == rptr;
    assign full  = (wptr[PTR_WIDTH-1:0] == rptr[PTR_WIDTH-1:0]) && (wptr[PTR_WIDTH] != rptr[PTR_WIDTH]);
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    fifo_mem #(.WIDTH(WIDTH), .DEPTH(FIFO_SIZE), .AW(PTR_WIDTH)) u_mem (
        .clk  (wr_clk),
        .we   (wr_ok),
        .waddr(wptr[PTR_WIDTH-1:0]),
        .wdata(wdata),
        .raddr(rptr[PTR_WIDTH-1:0]),
        .rdata(mem_rdata)
    );

    always_ff @(posedge wr_clk or negedge res) begin
        if (!res) begin
            wptr      <= '0;
            rptr      <= '0;
            rdata     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wptr <= wptr + PTR_ONE;
            if (rd_ok) begin
                rptr  <= rptr + PTR_ONE;
                rdata <= mem_rdata;
            end
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
        end
    end
endmodule

// File: tb/tb_async_fifo.sv
// tb_async_fifo: directed stimulus with a queue-based reference; expected
// per-cycle outputs are queued by the driver and checked by a separate monitor.
module tb_async_fifo;
    logic       wr_clk, res, wr_en, rd_en;
    logic [7:0] wdata, rdata;
    logic       full, empty, overflow, underflow;

    typedef struct {
        logic [7:0] rdata;
        logic       full, empty, ovf, udf;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mq[$];
    logic [7:0] last_rd;
    int         errors, checks;

    async_fifo dut (
        .wr_clk   (wr_clk),
        .res      (res),
        .wr_en    (wr_en),
        .wdata    (wdata),
        .rd_en    (rd_en),
        .rdata    (rdata),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .underflow(underflow)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle and queue the outputs expected after the edge
    task automatic cyc(input logic we, input logic [7:0] wd, input logic re);
        exp_t e;
        logic wacc, racc;
        @(negedge wr_clk);
        wr_en = we; wdata = wd; rd_en = re;
        @(posedge wr_clk);
        e.ovf = we && mq.size() == 16;
        e.udf = re && mq.size() == 0;
        wacc  = we && mq.size() != 16;
        racc  = re && mq.size() != 0;
        if (racc) last_rd = mq.pop_front();
        if (wacc) mq.push_back(wd);
        e.rdata = last_rd;
        e.full  = mq.size() == 16;
        e.empty = mq.size() == 0;
        sb.push_back(e);
    endtask

    always @(negedge wr_clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("rdata", {24'd0, rdata}, {24'd0, e.rdata});
            chk("full", {31'd0, full}, {31'd0, e.full});
            chk("empty", {31'd0, empty}, {31'd0, e.empty});
            chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
            chk("underflow", {31'd0, underflow}, {31'd0, e.udf});
        end
    end

    initial begin
        int wi, ri, guard;
        logic we, re;
        errors = 0; checks = 0; last_rd = 8'h00;
        res = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wdata = 8'h00;
        #3 res = 1'b0;
        #1;
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_rdata", {24'd0, rdata}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_udf", {31'd0, underflow}, 32'd0);
        @(negedge wr_clk) res = 1'b1;

        // FULL / OVERFLOW: 17 writes, the 17th is dropped
        for (int i = 1; i <= 17; i++) cyc(1'b1, 8'(i), 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        // EMPTY / UNDERFLOW: 17 reads, expect 0x01..0x10 then an underflow
        for (int i = 0; i < 17; i++) cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        chk("hold_after_udf", {24'd0, last_rd}, 32'h10);

        // Simultaneous requests when empty, then when full
        cyc(1'b1, 8'h55, 1'b1);
        for (int i = 0; i < 15; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0);
        cyc(1'b1, 8'h66, 1'b1);
        for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);

        // CONCURRENT: 20 random writes and 20 reads with random gaps
        wi = 0; ri = 0; guard = 0;
        while ((wi < 20 || ri < 20) && guard < 400) begin
            we = wi < 20 && mq.size() < 15 && $urandom_range(0, 1) == 1;
            re = ri < 20 && mq.size() > 0 && $urandom_range(0, 1) == 1;
            cyc(we, 8'($urandom_range(0, 255)), re);
            if (we) wi++;
            if (re) ri++;
            repeat ($urandom_range(0, 2)) cyc(1'b0, 8'h00, 1'b0);
            guard++;
        end
        chk("concurrent_done", wi * 100 + ri, 32'd2020);

        // RESET mid-burst
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hA0 + i), 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        @(negedge wr_clk);
        #2 res = 1'b0;
        #1;
        chk("mid_rst_empty", {31'd0, empty}, 32'd1);
        chk("mid_rst_full", {31'd0, full}, 32'd0);
        chk("mid_rst_rdata", {24'd0, rdata}, 32'd0);
        mq.delete();
        last_rd = 8'h00;
        wr_en = 1'b1; rd_en = 1'b1; wdata = 8'hEE;
        repeat (2) begin
            @(negedge wr_clk);
            chk("in_rst_empty", {31'd0, empty}, 32'd1);
            chk("in_rst_rdata", {24'd0, rdata}, 32'd0);
            chk("in_rst_ovf", {31'd0, overflow}, 32'd0);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        res = 1'b1;
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);

        repeat (2) @(negedge wr_clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
